// File: rtl/led_status_pkg.sv
// Shared mode encodings, pulse sub-FSM states and write-legality helper
// for the multi-channel status-LED controller.
package led_status_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_OFF        = 3'd0;
   localparam logic [MODE_W-1:0] MODE_ON         = 3'd1;
   localparam logic [MODE_W-1:0] MODE_BLINK_SLOW = 3'd2;
   localparam logic [MODE_W-1:0] MODE_BLINK_FAST = 3'd3;
   localparam logic [MODE_W-1:0] MODE_PULSE      = 3'd4;

   typedef enum logic {
      PULSE_IDLE   = 1'b0,
      PULSE_ACTIVE = 1'b1
   } pulse_state_e;

   function automatic logic mode_legal(input logic [MODE_W-1:0] mode);
      return (mode <= MODE_PULSE);
   endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Free-running divider: registered one-cycle tick and a phase bit that
// toggles on every wrap of the 0..DIV-1 counter.
module blink_prescaler #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick,
   output logic phase
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             phase_q, phase_d;
   logic             wrap;

   always_comb begin
      wrap    = (cnt_q == CNT_MAX);
      cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
      tick_d  = wrap;
      phase_d = phase_q ^ wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         tick_q  <= tick_d;
         phase_q <= phase_d;
      end
   end

   assign tick  = tick_q;
   assign phase = phase_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED controller: per-channel OFF/ON/blink/pulse modes
// sharing two prescalers. Optional PWM dimming via LED_STATUS_DIM_EN.
module led_status_ctrl
   import led_status_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int SLOW_DIV  = 25_000_000,
   parameter int FAST_DIV  = 6_250_000,
   parameter int PULSE_LEN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [MODE_W-1:0] wr_mode,
   output logic [NUM_CH-1:0] led,
   output logic [NUM_CH-1:0] busy,
   output logic              err
`ifdef LED_STATUS_DIM_EN
   ,
   input  logic [3:0]        duty
`endif
);

   localparam int PCNT_W = $clog2(PULSE_LEN + 1);

   logic slow_tick, slow_phase, fast_phase;
   logic wr_ok;
   logic err_q;
   logic lit_en;

   blink_prescaler #(.DIV(SLOW_DIV)) u_slow (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (slow_tick),
      .phase (slow_phase)
   );

   blink_prescaler #(.DIV(FAST_DIV)) u_fast (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (),
      .phase (fast_phase)
   );

   assign wr_ok = ({1'b0, wr_ch} < (CH_W + 1)'(NUM_CH)) && mode_legal(wr_mode);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= wr_en && !wr_ok;
      end
   end

   assign err = err_q;

`ifdef LED_STATUS_DIM_EN
   logic [3:0] pwm_cnt_q, pwm_cnt_d;

   assign pwm_cnt_d = (pwm_cnt_q == 4'd14) ? 4'd0 : pwm_cnt_q + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= 4'd0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   // Counter never reaches 15, so duty>=15 keeps the LED fully lit.
   assign lit_en = (pwm_cnt_q < duty);
`else
   assign lit_en = 1'b1;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [MODE_W-1:0] mode_q, mode_d;
         pulse_state_e      pst_q, pst_d;
         logic [PCNT_W-1:0] pcnt_q, pcnt_d;
         logic              led_q, led_d;
         logic              wr_hit;
         logic              lit;

         assign wr_hit = wr_en && wr_ok && (wr_ch == CH_W'(gi));

         always_comb begin
            mode_d = mode_q;
            pst_d  = pst_q;
            pcnt_d = pcnt_q;
            lit    = 1'b0;

            unique case (mode_q)
               MODE_ON:         lit = 1'b1;
               MODE_BLINK_SLOW: lit = slow_phase;
               MODE_BLINK_FAST: lit = fast_phase;
               MODE_PULSE:      lit = 1'b1;
               default:         lit = 1'b0;
            endcase
            led_d = lit && lit_en;

            if (pst_q == PULSE_ACTIVE && slow_tick) begin
               if (pcnt_q == PCNT_W'(1)) begin
                  mode_d = MODE_OFF;
                  pst_d  = PULSE_IDLE;
                  pcnt_d = '0;
               end else begin
                  pcnt_d = pcnt_q - PCNT_W'(1);
               end
            end

            // A write on the expiry edge overrides the expiry above.
            if (wr_hit) begin
               mode_d = wr_mode;
               if (wr_mode == MODE_PULSE) begin
                  pst_d  = PULSE_ACTIVE;
                  pcnt_d = PCNT_W'(PULSE_LEN);
               end else begin
                  pst_d  = PULSE_IDLE;
                  pcnt_d = '0;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mode_q <= MODE_OFF;
               pst_q  <= PULSE_IDLE;
               pcnt_q <= '0;
               led_q  <= 1'b0;
            end else begin
               mode_q <= mode_d;
               pst_q  <= pst_d;
               pcnt_q <= pcnt_d;
               led_q  <= led_d;
            end
         end

         assign led[gi]  = led_q;
         assign busy[gi] = (pst_q == PULSE_ACTIVE);
      end
   endgenerate

endmodule
